// File: rtl/pipeline_scoreboard_if.sv
// Issue / write-back / drain signal bundle between the ID stage and the register scoreboard.
// The master side drives issue requests and retirements; the slave side is the scoreboard.
interface pipeline_scoreboard_if #(
    parameter int NREG = 16
);
    localparam int IDX_W = $clog2(NREG);

    logic             issue_valid;
    logic             issue_wb_en;
    logic [IDX_W-1:0] issue_dest;
    logic [IDX_W-1:0] issue_src1;
    logic [IDX_W-1:0] issue_src2;
    logic             issue_two_src;
    logic             freeze;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_dest;
    logic             drain_req;

    logic             hazard;
    logic             issue_fire;
    logic [NREG-1:0]  pending_mask;
    logic             busy;
    logic             drain_done;
    logic             underflow_err;

    modport master (
        output issue_valid, issue_wb_en, issue_dest, issue_src1, issue_src2,
               issue_two_src, freeze, wb_valid, wb_dest, drain_req,
        input  hazard, issue_fire, pending_mask, busy, drain_done, underflow_err
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest, issue_src1, issue_src2,
               issue_two_src, freeze, wb_valid, wb_dest, drain_req,
        output hazard, issue_fire, pending_mask, busy, drain_done, underflow_err
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Per-register pending-write scoreboard: stalls issue on RAW or counter-full hazards,
// tracks outstanding writes and offers a drain handshake that waits for all of them to retire.
module pipeline_scoreboard #(
    parameter int NREG  = 16,
    parameter int CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_scoreboard_if.slave sb
);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic [NREG-1:0]  pending;
    logic             nxt_zero;
    logic             src1_pend;
    logic             src2_pend;
    logic             dest_full;
    logic             hazard;
    logic             issue_fire;
    logic             inc;
    logic             underflow_set;
    logic             underflow_err;

    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] cur,
        input logic             up,
        input logic             down
    );
        logic [CNT_W-1:0] res;
        res = cur;
        if (up && !down) begin
            res = cur + CNT_W'(1);
        end else if (down && !up) begin
            res = cur - CNT_W'(1);
        end
        return res;
    endfunction

    // Hazard looks only at registered counters; a same-cycle retirement is not bypassed.
    assign src1_pend  = (cnt[sb.issue_src1] != '0);
    assign src2_pend  = sb.issue_two_src && (cnt[sb.issue_src2] != '0);
    assign dest_full  = sb.issue_wb_en && (cnt[sb.issue_dest] == CNT_MAX);
    assign hazard     = sb.issue_valid && (src1_pend || src2_pend || dest_full || (state == DRAIN));
    assign issue_fire = sb.issue_valid && !hazard && !sb.freeze;
    assign inc        = issue_fire && sb.issue_wb_en;

    // A retirement matching a same-cycle issue to that register cancels it, even from zero.
    assign underflow_set = sb.wb_valid && (cnt[sb.wb_dest] == '0)
                           && !(inc && (sb.issue_dest == sb.wb_dest));

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        nxt_zero = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            inc_vec[i] = inc && (sb.issue_dest == IDX_W'(i));
            dec_vec[i] = sb.wb_valid && (sb.wb_dest == IDX_W'(i))
                         && ((cnt[i] != '0) || inc_vec[i]);
            cnt_nxt[i] = cnt_step(cnt[i], inc_vec[i], dec_vec[i]);
            nxt_zero   = nxt_zero && (cnt_nxt[i] == '0);
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NREG; i++) begin
            pending[i] = (cnt[i] != '0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sb.drain_req) begin
                    state_nxt = (pending != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (nxt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State boundary: counters, drain FSM and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            state         <= IDLE;
            underflow_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            state         <= state_nxt;
            underflow_err <= underflow_err || underflow_set;
        end
    end

    assign sb.hazard        = hazard;
    assign sb.issue_fire    = issue_fire;
    assign sb.pending_mask  = pending;
    assign sb.busy          = (pending != '0);
    assign sb.drain_done    = (state == DONE);
    assign sb.underflow_err = underflow_err;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: directed vector table, reset corner cases and
// randomized traffic against a counter-array reference model.
module tb_pipeline_scoreboard;
    logic clk = 1'b0;
    logic rst;

    pipeline_scoreboard_if #(.NREG(16)) sb ();

    pipeline_scoreboard #(.NREG(16), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, wben;
        logic [3:0]  dest, s1, s2;
        logic        two, frz, wbv;
        logic [3:0]  wd;
        logic        dr;
        logic        haz, fire;
        logic [15:0] mask;
        logic        done, uf;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t cur;
    vec_t tbl [28];

    // Reference model: outstanding write count per register plus drain phase flags.
    int   mcnt [16];
    bit   m_drain;
    bit   m_done;
    bit   m_uf;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int iv, input int wben, input int dest, input int s1,
                                input int s2, input int two, input int frz, input int wbv,
                                input int wd, input int dr, input int haz, input int fire,
                                input int mask, input int done, input int uf);
        vec_t v;
        v.iv = iv[0]; v.wben = wben[0]; v.dest = dest[3:0]; v.s1 = s1[3:0]; v.s2 = s2[3:0];
        v.two = two[0]; v.frz = frz[0]; v.wbv = wbv[0]; v.wd = wd[3:0]; v.dr = dr[0];
        v.haz = haz[0]; v.fire = fire[0]; v.mask = mask[15:0]; v.done = done[0]; v.uf = uf[0];
        return v;
    endfunction

    function automatic vec_t idle_vec();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive();
        sb.issue_valid   = cur.iv;
        sb.issue_wb_en   = cur.wben;
        sb.issue_dest    = cur.dest;
        sb.issue_src1    = cur.s1;
        sb.issue_src2    = cur.s2;
        sb.issue_two_src = cur.two;
        sb.freeze        = cur.frz;
        sb.wb_valid      = cur.wbv;
        sb.wb_dest       = cur.wd;
        sb.drain_req     = cur.dr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        m_drain = 0;
        m_done  = 0;
        m_uf    = 0;
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = (mcnt[i] > 0);
        return m;
    endfunction

    function automatic bit model_hazard();
        return cur.iv && (mcnt[cur.s1] > 0 || (cur.two && mcnt[cur.s2] > 0)
                          || (cur.wben && mcnt[cur.dest] == 3) || m_drain);
    endfunction

    task automatic check_model(input string tag);
        bit haz;
        bit fire;
        haz  = model_hazard();
        fire = cur.iv && !haz && !cur.frz;
        chk({tag, ".hazard"},     16'(sb.hazard),        16'(haz));
        chk({tag, ".issue_fire"}, 16'(sb.issue_fire),    16'(fire));
        chk({tag, ".pending"},    sb.pending_mask,       model_mask());
        chk({tag, ".busy"},       16'(sb.busy),          16'(model_mask() != 0));
        chk({tag, ".drain_done"}, 16'(sb.drain_done),    16'(m_done));
        chk({tag, ".underflow"},  16'(sb.underflow_err), 16'(m_uf));
    endtask

    // Applies the rules of one rising edge to the model using this cycle's inputs.
    task automatic model_step();
        bit haz, fire, inc, busy_before;
        int total;
        haz         = model_hazard();
        fire        = cur.iv && !haz && !cur.frz;
        inc         = fire && cur.wben;
        busy_before = (model_mask() != 0);
        if (cur.wbv && inc && cur.wd == cur.dest) begin
            // issue and retirement of the same register cancel out
        end else begin
            if (inc) mcnt[cur.dest]++;
            if (cur.wbv) begin
                if (mcnt[cur.wd] > 0) mcnt[cur.wd]--;
                else m_uf = 1;
            end
        end
        total = 0;
        for (int i = 0; i < 16; i++) total += mcnt[i];
        if (m_done) m_done = 0;
        else if (m_drain) begin
            if (total == 0) begin
                m_drain = 0;
                m_done  = 1;
            end
        end else if (cur.dr) begin
            if (busy_before) m_drain = 1;
            else m_done = 1;
        end
    endtask

    task automatic run_cycle(input string tag);
        drive();
        #2;
        check_model(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int   r;
        v      = idle_vec();
        v.iv   = ($urandom_range(0, 3) != 0);
        v.wben = ($urandom_range(0, 3) != 0);
        v.dest = 4'($urandom_range(0, 5));
        v.s1   = 4'($urandom_range(0, 15));
        v.s2   = 4'($urandom_range(0, 7));
        v.two  = $urandom_range(0, 1);
        v.frz  = ($urandom_range(0, 4) == 0);
        v.wbv  = $urandom_range(0, 1);
        r      = $urandom_range(0, 5);
        if (mcnt[r] == 0 && $urandom_range(0, 19) != 0)
            for (int k = 0; k < 16; k++) if (mcnt[k] != 0) r = k;
        v.wd   = 4'(r);
        v.dr   = ($urandom_range(0, 24) == 0);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // iv wben dest s1 s2 two frz wbv wd dr | haz fire mask done uf
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 0);
        tbl[2]  = mk(1, 0, 0, 5, 0, 0, 0, 1, 5, 0,  1, 0, 16'h0020, 0, 0);
        tbl[3]  = mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 0);
        tbl[4]  = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 7, 0, 0, 0, 0, 0,  0, 1, 16'h0080, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 16'h0080, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 16'h0080, 0, 0);
        tbl[8]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 0);
        tbl[9]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0008, 0, 0);
        tbl[10] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0008, 0, 0);
        tbl[11] = mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 16'h0008, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 16'h0008, 0, 0);
        tbl[13] = mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0,  0, 1, 16'h0008, 0, 0);
        tbl[14] = mk(1, 1, 3, 0, 0, 0, 1, 1, 3, 0,  0, 0, 16'h0008, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 16'h0008, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 16'h0000, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1);
        tbl[19] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0000, 0, 1);
        tbl[20] = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0002, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 16'h0006, 0, 1);
        tbl[22] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 16'h0006, 0, 1);
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 1,  1, 0, 16'h0004, 0, 1);
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 16'h0000, 1, 1);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 16'h0000, 0, 1);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 1);
        tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1);

        // Reset state, with an issue request present while rst is low.
        rst = 1'b0;
        model_reset();
        cur = mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive();
        #2;
        chk("rst.pending", sb.pending_mask, 16'h0000);
        chk("rst.hazard", 16'(sb.hazard), 16'h0000);
        chk("rst.issue_fire", 16'(sb.issue_fire), 16'h0001);
        check_model("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 28; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cur = tbl[i];
            drive();
            #2;
            chk({tag, ".hazard"},     16'(sb.hazard),        16'(tbl[i].haz));
            chk({tag, ".issue_fire"}, 16'(sb.issue_fire),    16'(tbl[i].fire));
            chk({tag, ".pending"},    sb.pending_mask,       tbl[i].mask);
            chk({tag, ".busy"},       16'(sb.busy),          16'(tbl[i].mask != 0));
            chk({tag, ".drain_done"}, 16'(sb.drain_done),    16'(tbl[i].done));
            chk({tag, ".underflow"},  16'(sb.underflow_err), 16'(tbl[i].uf));
            check_model(tag);
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a drain with cnt[2]=2.
        cur = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle("md.issue_a");
        run_cycle("md.issue_b");
        cur = idle_vec(); cur.dr = 1;
        run_cycle("md.req");
        cur = idle_vec(); cur.iv = 1; cur.s1 = 4'd9;
        run_cycle("md.drain");
        drive();
        #2 rst = 1'b0;
        #1;
        chk("md.rst.pending", sb.pending_mask, 16'h0000);
        chk("md.rst.busy", 16'(sb.busy), 16'h0000);
        chk("md.rst.hazard", 16'(sb.hazard), 16'h0000);
        chk("md.rst.drain_done", 16'(sb.drain_done), 16'h0000);
        chk("md.rst.underflow", 16'(sb.underflow_err), 16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cur = idle_vec(); cur.wbv = 1; cur.wd = 4'd2;
        run_cycle("md.late_wb0");
        run_cycle("md.late_wb1");
        cur = idle_vec();
        for (int i = 0; i < 4; i++) begin
            chk("md.no_done", 16'(sb.drain_done), 16'h0000);
            run_cycle("md.idle");
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if (n % 500 == 250) begin
                cur = idle_vec();
                drive();
                rst = 1'b0;
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            cur = rand_vec();
            run_cycle($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
